i2s_rx_unit: RTL and testbench
==============================

# i2s_rx_unit

I2S serial receiver: the receiving end of the link driven by the audioport's I2S transmitter. It samples sck/ws/sdi in the system clock domain, deserialises 24-bit MSB-first left (ws=0) and right (ws=1) slots, and presents each complete stereo frame as a parallel sample pair with a one-cycle valid pulse. It is used as a loopback/monitor receiver in audioport test systems and in codec-input paths.

## Interface
- I2S_RX_W, 24, sample width per channel (package constant, not overridable per instance)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable_in  in  1  receiver enable; low forces IDLE
- sck_in  in  1  I2S bit clock, slower than clk, high and low phases each ≥1 clk cycle
- ws_in  in  1  word select: 0 = left/audio0, 1 = right/audio1; changes only with falling sck
- sdi_in  in  1  serial data, MSB first; changes only with falling sck
- audio0_out  out  24  last complete left sample
- audio1_out  out  24  last complete right sample
- valid_out  out  1  one-cycle pulse: new audio0_out/audio1_out pair
- err_out  out  1  one-cycle pulse: short slot (fewer than 24 bits before ws changed)
- locked_out  out  1  high in LEFT/RIGHT states

## Operation
- Rising sck edge detected as sck=1 with previous-cycle sck=0 ("rise"); ws and sdi are sampled in the rise cycle only. Falling edges are ignored.
- ws_prev holds the ws value of the previous rise. A boundary is a rise with ws ≠ ws_prev; that rise also carries the new slot's MSB (left-justified, no one-bit delay).
- bit_cnt is 5 bits. It is loaded to 1 on a slot's first bit, incremented per rise, and saturates at 24. Bits after the 24th in a slot are ignored, which allows 32-bit slots.
- The shift register shifts left with sdi at the LSB only while bit_cnt < 24.
- FSM:
  - IDLE: leave when enable_in=1 → SYNC.
  - SYNC: on a boundary with ws=0 → LEFT, capture bit 1.
  - LEFT: on a boundary with ws=1:
    - bit_cnt=24 → copy shift to left_hold, → RIGHT, capture bit 1.
    - else → err_out pulse, → SYNC.
  - RIGHT: when the 24th bit is captured → audio0_out←left_hold, audio1_out←shift, valid_out pulse. On a boundary with ws=0:
    - bit_cnt=24 → LEFT, capture bit 1.
    - else → err_out pulse, → LEFT, capture bit 1 (a left start is valid even after a short right slot).
- enable_in=0 in any state: → IDLE next cycle. A partial frame is discarded with no valid_out and no err_out. audio outputs hold their values.
- Reset values: state IDLE; audio0_out, audio1_out, left_hold, shift, bit_cnt, ws_prev all 0; valid_out, err_out, locked_out 0; sck history 0.

## Timing
- valid_out is registered: asserted in the clk cycle after the rise that captures the 24th right bit. audio outputs update in that same cycle.
- err_out has the same latency relative to the offending boundary rise.
- The first frame after enable needs one full right slot to establish ws_prev=1. Earliest valid_out comes one full frame after the first left boundary.
- A rise coinciding with enable_in falling is ignored.
- Reset asserted mid-frame clears everything immediately (asynchronous).

## Configuration
- I2S_RX_SYNC_EN defined: sck_in, ws_in, sdi_in each pass through a 2-flop synchroniser, reset to 0, before edge detection. All latencies grow by 2 clk cycles. Required for asynchronous external codecs.
- Not defined: inputs feed edge detection directly. This is legal only when the transmitter is clocked by clk.

## Structure
- audioport_pkg holds:
  - I2S_RX_W = 24
  - typedef enum logic [1:0] i2s_rx_state_t {RX_IDLE, RX_SYNC, RX_LEFT, RX_RIGHT}
- Sub-module i2s_rx_sampler contains the optional synchroniser, the sck edge detector and the ws/sdi capture. Its outputs are rise_out, ws_s_out and sdi_s_out.
- Parent i2s_rx_unit holds the FSM, counter, shift register and output registers.

## Test plan
- Normal frame: enable=1, sck period 8 clk, send left 0xA5A5A5 then right 0x5A5A5A, repeat → second frame gives valid_out one pulse, audio0_out=0xA5A5A5, audio1_out=0x5A5A5A.
- 32-bit slots: each slot has 24 data bits then 8 zero bits, values 0x123456/0xFEDCBA → same outputs; trailing bits ignored.
- Short slot: left slot has only 20 bits before ws rises → err_out one pulse, no valid_out for that frame; next full frame is received correctly.
- Disable mid-frame: enable_in low after 10 right bits → no valid_out, no err_out; audio outputs keep previous values; state IDLE.
- Fastest sck (period 2 clk, 1 high / 1 low), random data for 100 frames → every frame received, valid_out spacing exactly 96 clk.
- Reset mid-frame: rst_n pulsed low during a left slot → all outputs 0 immediately; receiver relocks and outputs the correct pair after one full frame.

Source files
------------

// File: rtl/audioport_pkg.sv
// Shared constants and types for the audioport I2S receive path.
package audioport_pkg;

    localparam int unsigned I2S_RX_W     = 24;
    localparam int unsigned I2S_RX_CNT_W = 5;

    localparam logic [I2S_RX_CNT_W-1:0] I2S_RX_CNT_ONE  = I2S_RX_CNT_W'(1);
    localparam logic [I2S_RX_CNT_W-1:0] I2S_RX_CNT_FULL = I2S_RX_CNT_W'(I2S_RX_W);
    localparam logic [I2S_RX_CNT_W-1:0] I2S_RX_CNT_LAST = I2S_RX_CNT_W'(I2S_RX_W - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SYNC,
        RX_LEFT,
        RX_RIGHT
    } i2s_rx_state_t;

endpackage

// File: rtl/i2s_rx_sampler.sv
// I2S input sampler: optional 2-flop synchroniser (I2S_RX_SYNC_EN), sck rise
// detector, and ws/sdi presented for capture in the rise cycle.
module i2s_rx_sampler (
    input  logic clk,
    input  logic rst_n,
    input  logic sck_in,
    input  logic ws_in,
    input  logic sdi_in,
    output logic rise_out,
    output logic ws_s_out,
    output logic sdi_s_out
);

    logic sck_c;
    logic ws_c;
    logic sdi_c;
    logic sck_prev_q;

`ifdef I2S_RX_SYNC_EN
    logic [1:0] sck_sync_q;
    logic [1:0] ws_sync_q;
    logic [1:0] sdi_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q <= '0;
            ws_sync_q  <= '0;
            sdi_sync_q <= '0;
        end else begin
            sck_sync_q <= {sck_sync_q[0], sck_in};
            ws_sync_q  <= {ws_sync_q[0], ws_in};
            sdi_sync_q <= {sdi_sync_q[0], sdi_in};
        end
    end

    assign sck_c = sck_sync_q[1];
    assign ws_c  = ws_sync_q[1];
    assign sdi_c = sdi_sync_q[1];
`else
    // Only safe when the transmitter runs from clk itself.
    assign sck_c = sck_in;
    assign ws_c  = ws_in;
    assign sdi_c = sdi_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_prev_q <= 1'b0;
        end else begin
            sck_prev_q <= sck_c;
        end
    end

    assign rise_out  = sck_c & ~sck_prev_q;
    assign ws_s_out  = ws_c;
    assign sdi_s_out = sdi_c;

endmodule

// File: rtl/i2s_rx_unit.sv
// I2S receiver: deserialises 24-bit left/right slots into parallel stereo pairs.
// Define I2S_RX_SYNC_EN to synchronise sck/ws/sdi from an asynchronous codec.
module i2s_rx_unit
    import audioport_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_in,
    input  logic                sck_in,
    input  logic                ws_in,
    input  logic                sdi_in,
    output logic [I2S_RX_W-1:0] audio0_out,
    output logic [I2S_RX_W-1:0] audio1_out,
    output logic                valid_out,
    output logic                err_out,
    output logic                locked_out
);

    logic rise;
    logic ws_s;
    logic sdi_s;

    i2s_rx_sampler u_sampler (
        .clk       (clk),
        .rst_n     (rst_n),
        .sck_in    (sck_in),
        .ws_in     (ws_in),
        .sdi_in    (sdi_in),
        .rise_out  (rise),
        .ws_s_out  (ws_s),
        .sdi_s_out (sdi_s)
    );

    i2s_rx_state_t           state_q,     state_d;
    logic                    ws_prev_q,   ws_prev_d;
    logic [I2S_RX_CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic [I2S_RX_W-1:0]     shift_q,     shift_d;
    logic [I2S_RX_W-1:0]     left_hold_q, left_hold_d;
    logic [I2S_RX_W-1:0]     audio0_q,    audio0_d;
    logic [I2S_RX_W-1:0]     audio1_q,    audio1_d;
    logic                    valid_q,     valid_d;
    logic                    err_q,       err_d;

    logic                    boundary;
    logic                    cnt_full;
    logic                    slot_start;
    logic                    data_bit;
    logic [I2S_RX_W-1:0]     shift_in;

    assign boundary = rise & (ws_s != ws_prev_q);
    assign cnt_full = (bit_cnt_q == I2S_RX_CNT_FULL);
    assign shift_in = {shift_q[I2S_RX_W-2:0], sdi_s};

    always_comb begin
        state_d     = state_q;
        ws_prev_d   = ws_prev_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        audio0_d    = audio0_q;
        audio1_d    = audio1_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        slot_start  = 1'b0;
        data_bit    = 1'b0;

        if (!enable_in) begin
            state_d = RX_IDLE;
        end else begin
            if (rise) begin
                ws_prev_d = ws_s;
            end

            case (state_q)
                RX_IDLE: begin
                    state_d = RX_SYNC;
                end
                RX_SYNC: begin
                    if (boundary && !ws_s) begin
                        state_d    = RX_LEFT;
                        slot_start = 1'b1;
                    end
                end
                RX_LEFT: begin
                    if (boundary) begin
                        if (cnt_full) begin
                            left_hold_d = shift_q;
                            state_d     = RX_RIGHT;
                            slot_start  = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = RX_SYNC;
                        end
                    end else if (rise) begin
                        data_bit = 1'b1;
                    end
                end
                RX_RIGHT: begin
                    // A short right slot is flagged but its boundary still starts a left slot.
                    if (boundary) begin
                        err_d      = ~cnt_full;
                        state_d    = RX_LEFT;
                        slot_start = 1'b1;
                    end else if (rise) begin
                        data_bit = 1'b1;
                        if (bit_cnt_q == I2S_RX_CNT_LAST) begin
                            audio0_d = left_hold_q;
                            audio1_d = shift_in;
                            valid_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = RX_IDLE;
                end
            endcase

            if (slot_start) begin
                bit_cnt_d = I2S_RX_CNT_ONE;
                shift_d   = shift_in;
            end else if (data_bit && !cnt_full) begin
                bit_cnt_d = bit_cnt_q + I2S_RX_CNT_ONE;
                shift_d   = shift_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RX_IDLE;
            ws_prev_q   <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            audio0_q    <= '0;
            audio1_q    <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ws_prev_q   <= ws_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            audio0_q    <= audio0_d;
            audio1_q    <= audio1_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign audio0_out = audio0_q;
    assign audio1_out = audio1_q;
    assign valid_out  = valid_q;
    assign err_out    = err_q;
    assign locked_out = (state_q == RX_LEFT) || (state_q == RX_RIGHT);

endmodule

// File: tb/tb_i2s_rx_unit.sv
// Self-checking bench for i2s_rx_unit (default build, inputs clocked from clk).
module tb_i2s_rx_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_in;
    logic        sck_in;
    logic        ws_in;
    logic        sdi_in;
    logic [23:0] audio0_out;
    logic [23:0] audio1_out;
    logic        valid_out;
    logic        err_out;
    logic        locked_out;

    always #5 clk = ~clk;

    i2s_rx_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_in  (enable_in),
        .sck_in     (sck_in),
        .ws_in      (ws_in),
        .sdi_in     (sdi_in),
        .audio0_out (audio0_out),
        .audio1_out (audio1_out),
        .valid_out  (valid_out),
        .err_out    (err_out),
        .locked_out (locked_out)
    );

    typedef struct {
        logic [23:0] a0;
        logic [23:0] a1;
        int unsigned t;
    } obs_t;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
    } pair_t;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        int unsigned bits;
        int unsigned hi;
        int unsigned lo;
        int unsigned exp_valids;
        logic [23:0] exp_a0;
        logic [23:0] exp_a1;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int unsigned err_pulses = 0;
    obs_t        vq[$];
    pair_t       exp_q[$];

    // Observation: every cycle with valid_out high is one reported pair.
    always @(negedge clk) begin
        cyc++;
        if (valid_out) vq.push_back('{audio0_out, audio1_out, cyc});
        if (err_out) err_pulses++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic w, input logic d, input int unsigned hi, input int unsigned lo);
        sck_in = 1'b0;
        ws_in  = w;
        sdi_in = d;
        repeat (lo) @(posedge clk);
        #1;
        sck_in = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
    endtask

    task automatic send_slot(input logic w, input logic [23:0] data, input int unsigned nbits,
                             input int unsigned hi, input int unsigned lo);
        for (int unsigned i = 0; i < nbits; i++)
            drive_bit(w, (i < 24) ? data[23 - i] : 1'b0, hi, lo);
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int unsigned nbits,
                              input int unsigned hi, input int unsigned lo);
        send_slot(1'b0, l, nbits, hi, lo);
        send_slot(1'b1, r, nbits, hi, lo);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        enable_in = 1'b0;
        sck_in    = 1'b0;
        ws_in     = 1'b0;
        sdi_in    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        enable_in = 1'b1;
        @(posedge clk);
        #1;
        vq.delete();
        exp_q.delete();
        err_pulses = 0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_pairs(input string name);
        check({name, "_count"}, vq.size(), exp_q.size());
        for (int i = 0; i < vq.size() && i < exp_q.size(); i++) begin
            check({name, "_a0"}, {8'h0, vq[i].a0}, {8'h0, exp_q[i].l});
            check({name, "_a1"}, {8'h0, vq[i].a1}, {8'h0, exp_q[i].r});
        end
    endtask

    vec_t  vecs[6];
    pair_t f0, f1, x, y, lp;

    initial begin
        vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, 24, 4, 4, 2, 24'hA5A5A5, 24'h5A5A5A};
        vecs[1] = '{24'h123456, 24'hFEDCBA, 32, 4, 4, 2, 24'h123456, 24'hFEDCBA};
        vecs[2] = '{24'h000000, 24'hFFFFFF, 24, 1, 1, 2, 24'h000000, 24'hFFFFFF};
        vecs[3] = '{24'h800001, 24'h7FFFFE, 24, 1, 3, 2, 24'h800001, 24'h7FFFFE};
        for (int i = 4; i < 6; i++) begin
            vecs[i].l    = 24'($urandom);
            vecs[i].r    = 24'($urandom);
            vecs[i].bits = (i == 4) ? 24 : 32;
            vecs[i].hi   = $urandom_range(1, 3);
            vecs[i].lo   = $urandom_range(1, 3);
            vecs[i].exp_valids = 2;
            vecs[i].exp_a0 = vecs[i].l;
            vecs[i].exp_a1 = vecs[i].r;
        end

        // Reset state, and a disabled receiver stays unlocked.
        rst_n = 1'b0; enable_in = 1'b0; sck_in = 1'b0; ws_in = 1'b0; sdi_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_audio0", {8'h0, audio0_out}, 32'h0);
        check("rst_audio1", {8'h0, audio1_out}, 32'h0);
        check("rst_valid", {31'h0, valid_out}, 32'h0);
        check("rst_err", {31'h0, err_out}, 32'h0);
        check("rst_locked", {31'h0, locked_out}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("disabled_locked", {31'h0, locked_out}, 32'h0);

        // Clean streams: the first frame only establishes lock, later frames report.
        foreach (vecs[v]) begin
            do_reset();
            for (int f = 0; f < 3; f++)
                send_frame(vecs[v].l, vecs[v].r, vecs[v].bits, vecs[v].hi, vecs[v].lo);
            settle();
            check($sformatf("vec%0d_count", v), vq.size(), vecs[v].exp_valids);
            foreach (vq[k]) begin
                check($sformatf("vec%0d_a0", v), {8'h0, vq[k].a0}, {8'h0, vecs[v].exp_a0});
                check($sformatf("vec%0d_a1", v), {8'h0, vq[k].a1}, {8'h0, vecs[v].exp_a1});
            end
            check($sformatf("vec%0d_err", v), err_pulses, 0);
            check($sformatf("vec%0d_locked", v), {31'h0, locked_out}, 32'h1);
        end

        // Short left slot: one error, that frame dropped, next frame good.
        do_reset();
        f0 = '{24'h111111, 24'h222222}; f1 = '{24'h333333, 24'h444444};
        x  = '{24'hDEADBE, 24'hEF0123}; lp = '{24'h0F0F0F, 24'hF0F0F0};
        send_frame(f0.l, f0.r, 24, 2, 2);
        send_frame(f1.l, f1.r, 24, 2, 2);
        exp_q.push_back(f1);
        send_slot(1'b0, x.l, 20, 2, 2);
        send_slot(1'b1, x.r, 24, 2, 2);
        send_frame(lp.l, lp.r, 24, 2, 2);
        exp_q.push_back(lp);
        settle();
        check("short_err", err_pulses, 1);
        check_pairs("short");

        // Disable mid right slot: nothing reported, outputs hold, unlocked.
        do_reset();
        send_frame(f0.l, f0.r, 24, 2, 2);
        send_frame(f1.l, f1.r, 24, 2, 2);
        exp_q.push_back(f1);
        send_slot(1'b0, x.l, 24, 2, 2);
        send_slot(1'b1, x.r, 10, 2, 2);
        enable_in = 1'b0;
        send_slot(1'b1, 24'hFFFFFF, 14, 2, 2);
        settle();
        check("dis_err", err_pulses, 0);
        check_pairs("dis");
        check("dis_audio0", {8'h0, audio0_out}, {8'h0, f1.l});
        check("dis_audio1", {8'h0, audio1_out}, {8'h0, f1.r});
        check("dis_locked", {31'h0, locked_out}, 32'h0);

        // Asynchronous reset mid left slot, then relock.
        do_reset();
        send_frame(f0.l, f0.r, 24, 2, 2);
        send_frame(f1.l, f1.r, 24, 2, 2);
        for (int i = 0; i < 12; i++) drive_bit(1'b0, x.l[23 - i], 2, 2);
        check("pre_rst_audio0", {8'h0, audio0_out}, {8'h0, f1.l});
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_audio0", {8'h0, audio0_out}, 32'h0);
        check("mid_rst_audio1", {8'h0, audio1_out}, 32'h0);
        check("mid_rst_locked", {31'h0, locked_out}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vq.delete();
        exp_q.delete();
        err_pulses = 0;
        for (int i = 12; i < 24; i++) drive_bit(1'b0, x.l[23 - i], 2, 2);
        send_slot(1'b1, x.r, 24, 2, 2);
        send_frame(lp.l, lp.r, 24, 2, 2);
        exp_q.push_back(lp);
        settle();
        check("relock_err", err_pulses, 0);
        check_pairs("relock");

        // Fastest sck with random data: every frame after the first, 96 clk apart.
        do_reset();
        for (int f = 0; f < 101; f++) begin
            pair_t p;
            p.l = 24'($urandom);
            p.r = 24'($urandom);
            if (f > 0) exp_q.push_back(p);
            send_frame(p.l, p.r, 24, 1, 1);
        end
        settle();
        check("fast_err", err_pulses, 0);
        check_pairs("fast");
        for (int i = 1; i < vq.size(); i++)
            check("fast_spacing", vq[i].t - vq[i - 1].t, 96);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
